sorted_stream_checker: RTL and testbench

//  Sink at the downstream end of the merge network. Consumes the record stream
//  (2^E_LOG records per beat, key in low KEYW bits of each record) and checks it
//  is globally ascending. Counts records, flags the first ordering violation
//  (sticky) and raises DONE once NUM_RECORDS records have passed.

---
 rtl/sorted_stream_checker_pkg.sv | 20 ++
 rtl/sorted_stream_checker_beat_order_check.sv | 27 ++
 rtl/sorted_stream_checker.sv | 147 ++++++++++++++
 tb/tb_sorted_stream_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorted_stream_checker_pkg.sv
// Shared definitions for the sorted-stream checker, merge network and stream generators.
// Holds default geometry, error codes and checker FSM state encodings.
package sorted_stream_checker_pkg;

  localparam int unsigned DEF_E_LOG = 2;
  localparam int unsigned DEF_DATW  = 64;
  localparam int unsigned DEF_KEYW  = 32;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_INTRA   = 2'd1;
  localparam logic [1:0] ERR_INTER   = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StDone = 2'd1,
    StFail = 2'd2
  } chk_state_e;

endpackage

// File: rtl/sorted_stream_checker_beat_order_check.sv
// Combinational check that the E keys of one beat are non-decreasing from lane 0 upward.
// Also exposes the first and last lane keys for the inter-beat comparison.
module beat_order_check #(
  parameter int unsigned E_LOG = 2,
  parameter int unsigned KEYW  = 32
) (
  input  logic [(KEYW << E_LOG)-1:0] keys,
  output logic                       intra_ok,
  output logic [KEYW-1:0]            key_first,
  output logic [KEYW-1:0]            key_last
);

  localparam int unsigned E = 1 << E_LOG;

  always_comb begin
    intra_ok = 1'b1;
    for (int i = 0; i < int'(E) - 1; i++) begin
      if (keys[KEYW*i +: KEYW] > keys[KEYW*(i+1) +: KEYW]) begin
        intra_ok = 1'b0;
      end
    end
  end

  assign key_first = keys[0 +: KEYW];
  assign key_last  = keys[KEYW*(E-1) +: KEYW];

endmodule

// File: rtl/sorted_stream_checker.sv
// Downstream sink that verifies a record stream is globally ascending by key.
// Counts records, latches the first ordering violation and flags completion.
module sorted_stream_checker
  import sorted_stream_checker_pkg::*;
#(
  parameter int unsigned E_LOG       = DEF_E_LOG,
  parameter int unsigned DATW        = DEF_DATW,
  parameter int unsigned KEYW        = DEF_KEYW,
  parameter int unsigned NUM_RECORDS = 32,
  parameter int unsigned CNTW        = 32
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CLR,
  input  logic [(DATW << E_LOG)-1:0] DIN,
  input  logic                       DINEN,
  output logic [CNTW-1:0]            RCNT,
  output logic                       DONE,
  output logic                       ERR,
  output logic [1:0]                 ERR_CODE,
  output logic [CNTW-1:0]            ERR_BEAT,
  output logic [KEYW-1:0]            LAST_KEY
);

  localparam int unsigned E = 1 << E_LOG;

  // Only key bits are registered; payload above KEYW is never examined.
  logic [(KEYW << E_LOG)-1:0] keys_in;
  logic [(KEYW << E_LOG)-1:0] d0_q;
  logic                       v0_q;

  always_comb begin
    keys_in = '0;
    for (int i = 0; i < int'(E); i++) begin
      keys_in[KEYW*i +: KEYW] = DIN[DATW*i +: KEYW];
    end
  end

  logic            intra_ok;
  logic [KEYW-1:0] key_first;
  logic [KEYW-1:0] key_last;

  beat_order_check #(
    .E_LOG (E_LOG),
    .KEYW  (KEYW)
  ) u_beat_order_check (
    .keys      (d0_q),
    .intra_ok  (intra_ok),
    .key_first (key_first),
    .key_last  (key_last)
  );

  chk_state_e      state_q, state_d;
  logic [CNTW-1:0] rcnt_q, rcnt_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNTW-1:0] err_beat_q, err_beat_d;
  logic [KEYW-1:0] last_key_q, last_key_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            first_q, first_d;
  logic            inter_ok;

  assign inter_ok = first_q || (key_first >= last_key_q);

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    beat_cnt_d = beat_cnt_q;
    err_beat_d = err_beat_q;
    last_key_d = last_key_q;
    err_code_d = err_code_q;
    done_d     = done_q;
    err_d      = err_q;
    first_d    = first_q;
    unique case (state_q)
      StRun: begin
        if (v0_q) begin
          if (!intra_ok || !inter_ok) begin
            state_d    = StFail;
            err_d      = 1'b1;
            err_beat_d = beat_cnt_q;
            err_code_d = !intra_ok ? ERR_INTRA : ERR_INTER;
          end else begin
            rcnt_d     = rcnt_q + CNTW'(E);
            beat_cnt_d = beat_cnt_q + 1'b1;
            last_key_d = key_last;
            first_d    = 1'b0;
            if (rcnt_d == CNTW'(NUM_RECORDS)) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
      end
      StDone: begin
        if (v0_q) begin
          state_d    = StFail;
          done_d     = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
          err_beat_d = CNTW'(NUM_RECORDS / E);
        end
      end
      StFail: begin
        // Held until CLR or reset.
      end
      default: state_d = StFail;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || CLR) begin
      d0_q       <= '0;
      v0_q       <= 1'b0;
      state_q    <= StRun;
      rcnt_q     <= '0;
      beat_cnt_q <= '0;
      err_beat_q <= '0;
      last_key_q <= '0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      d0_q       <= keys_in;
      v0_q       <= DINEN;
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_beat_q <= err_beat_d;
      last_key_q <= last_key_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      err_q      <= err_d;
      first_q    <= first_d;
    end
  end

  assign RCNT     = rcnt_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERR_CODE = err_code_q;
  assign ERR_BEAT = err_beat_q;
  assign LAST_KEY = last_key_q;

endmodule

// File: tb/tb_sorted_stream_checker.sv
// Scenario bench for sorted_stream_checker: an expected-output scoreboard per beat
// plus direct end-of-scenario checks.
module tb_sorted_stream_checker;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CLR;
  logic [255:0] DIN;
  logic         DINEN;
  logic [31:0]  RCNT;
  logic         DONE;
  logic         ERR;
  logic [1:0]   ERR_CODE;
  logic [31:0]  ERR_BEAT;
  logic [31:0]  LAST_KEY;

  int checks = 0;
  int errors = 0;

  sorted_stream_checker #(
    .E_LOG       (2),
    .DATW        (64),
    .KEYW        (32),
    .NUM_RECORDS (32),
    .CNTW        (32)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLR      (CLR),
    .DIN      (DIN),
    .DINEN    (DINEN),
    .RCNT     (RCNT),
    .DONE     (DONE),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE),
    .ERR_BEAT (ERR_BEAT),
    .LAST_KEY (LAST_KEY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rcnt;
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic [31:0] beat;
    logic [31:0] last;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Reference model: 0 = running, 1 = done, 2 = failed
  int          m_state;
  logic [31:0] m_rcnt, m_beats, m_last, m_errbeat;
  logic        m_first, m_done, m_err;
  logic [1:0]  m_code;

  task automatic model_reset();
    m_state = 0; m_rcnt = 0; m_beats = 0; m_last = 0; m_errbeat = 0;
    m_first = 1'b1; m_done = 1'b0; m_err = 1'b0; m_code = 2'd0;
  endtask

  task automatic model_beat(input logic [31:0] k0, k1, k2, k3);
    exp_t x;
    if (m_state == 0) begin
      if (!(k0 <= k1 && k1 <= k2 && k2 <= k3)) begin
        m_state = 2; m_err = 1'b1; m_code = 2'd1; m_errbeat = m_beats;
      end else if (!m_first && k0 < m_last) begin
        m_state = 2; m_err = 1'b1; m_code = 2'd2; m_errbeat = m_beats;
      end else begin
        m_rcnt = m_rcnt + 4; m_beats = m_beats + 1; m_last = k3; m_first = 1'b0;
        if (m_rcnt == 32) begin
          m_state = 1; m_done = 1'b1;
        end
      end
    end else if (m_state == 1) begin
      m_state = 2; m_done = 1'b0; m_err = 1'b1; m_code = 2'd3; m_errbeat = 8;
    end
    x.rcnt = m_rcnt; x.done = m_done; x.err = m_err;
    x.code = m_code; x.beat = m_errbeat; x.last = m_last;
    sb.push_back(x);
  endtask

  // Tracks which edge a sampled beat becomes visible at the outputs.
  logic v_s = 1'b0;
  logic proc = 1'b0;

  always @(posedge CLK) begin
    if (!RST_N || CLR) begin
      v_s  <= 1'b0;
      proc <= 1'b0;
      sb.delete();
    end else begin
      v_s  <= DINEN;
      proc <= v_s;
    end
  end

  always @(negedge CLK) begin
    if (proc) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output update seen with no expected entry");
      end else begin
        e = sb.pop_front();
        if (RCNT !== e.rcnt || DONE !== e.done || ERR !== e.err || ERR_CODE !== e.code ||
            ERR_BEAT !== e.beat || LAST_KEY !== e.last) begin
          errors++;
          $display("FAIL scoreboard: got rcnt=%0d done=%b err=%b code=%0d beat=%0d last=%0d, exp rcnt=%0d done=%b err=%b code=%0d beat=%0d last=%0d",
                   RCNT, DONE, ERR, ERR_CODE, ERR_BEAT, LAST_KEY,
                   e.rcnt, e.done, e.err, e.code, e.beat, e.last);
        end
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive_beat(input logic [31:0] k0, k1, k2, k3);
    DIN   = {$urandom(), k3, $urandom(), k2, $urandom(), k1, $urandom(), k0};
    DINEN = 1'b1;
    model_beat(k0, k1, k2, k3);
    @(posedge CLK); #1;
    DINEN = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries still pending, required 0", sb.size());
      sb.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_clear();
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    model_reset();
  endtask

  task automatic send_full_stream(input int gap);
    for (int b = 0; b < 8; b++) begin
      drive_beat(4*b+1, 4*b+2, 4*b+3, 4*b+4);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_final(input string name, input logic [31:0] rcnt, input logic done,
                             input logic err, input logic [1:0] code, input logic [31:0] beat,
                             input logic [31:0] last);
    checks++;
    if (RCNT !== rcnt || DONE !== done || ERR !== err || ERR_CODE !== code ||
        ERR_BEAT !== beat || LAST_KEY !== last) begin
      errors++;
      $display("FAIL %s: got rcnt=%0d done=%b err=%b code=%0d beat=%0d last=%0d, exp rcnt=%0d done=%b err=%b code=%0d beat=%0d last=%0d",
               name, RCNT, DONE, ERR, ERR_CODE, ERR_BEAT, LAST_KEY,
               rcnt, done, err, code, beat, last);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (RCNT !== 32'd0 || DONE !== 1'b0 || ERR !== 1'b0 || ERR_CODE !== 2'd0 ||
        ERR_BEAT !== 32'd0 || LAST_KEY !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rcnt=%0d done=%b err=%b code=%0d beat=%0d last=%0d, exp all 0",
               RCNT, DONE, ERR, ERR_CODE, ERR_BEAT, LAST_KEY);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    send_full_stream(0);
    wait_drain();
    check_final("back_to_back", 32, 1'b1, 1'b0, 2'd0, 0, 32);
  endtask

  task automatic test_sparse();
    do_clear();
    send_full_stream(2);
    wait_drain();
    check_final("sparse", 32, 1'b1, 1'b0, 2'd0, 0, 32);
  endtask

  task automatic test_intra();
    do_clear();
    drive_beat(1, 2, 3, 4);
    drive_beat(5, 6, 7, 8);
    drive_beat(9, 11, 10, 12);
    drive_beat(13, 14, 15, 16);
    drive_beat(17, 18, 19, 20);
    wait_drain();
    check_final("intra", 8, 1'b0, 1'b1, 2'd1, 2, 8);
  endtask

  task automatic test_inter();
    do_clear();
    drive_beat(1, 2, 3, 4);
    drive_beat(4, 5, 6, 7);
    drive_beat(6, 8, 9, 10);
    wait_drain();
    check_final("inter", 8, 1'b0, 1'b1, 2'd2, 2, 7);
  endtask

  task automatic test_equal_keys();
    do_clear();
    drive_beat(5, 5, 5, 5);
    drive_beat(5, 5, 6, 6);
    wait_drain();
    check_final("equal_keys", 8, 1'b0, 1'b0, 2'd0, 0, 6);
  endtask

  task automatic test_overrun();
    do_clear();
    send_full_stream(0);
    drive_beat(33, 34, 35, 36);
    wait_drain();
    check_final("overrun", 32, 1'b0, 1'b1, 2'd3, 8, 32);
  endtask

  task automatic test_clear_restart();
    do_clear();
    for (int b = 0; b < 3; b++) drive_beat(4*b+1, 4*b+2, 4*b+3, 4*b+4);
    wait_drain();
    check_final("pre_clear", 12, 1'b0, 1'b0, 2'd0, 0, 12);
    do_clear();
    check_final("after_clear", 0, 1'b0, 1'b0, 2'd0, 0, 0);
    send_full_stream(0);
    wait_drain();
    check_final("clear_restart", 32, 1'b1, 1'b0, 2'd0, 0, 32);
  endtask

  task automatic test_reset_midrun();
    do_clear();
    for (int b = 0; b < 3; b++) drive_beat(4*b+1, 4*b+2, 4*b+3, 4*b+4);
    // Beat sampled on the edge just before reset must be discarded.
    drive_beat(13, 14, 15, 16);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    model_reset();
    check_final("reset_midrun", 0, 1'b0, 1'b0, 2'd0, 0, 0);
    idle(2);
    check_final("reset_discard", 0, 1'b0, 1'b0, 2'd0, 0, 0);
    drive_beat(3, 3, 4, 9);
    wait_drain();
    check_final("after_reset_run", 4, 1'b0, 1'b0, 2'd0, 0, 9);
  endtask

  initial begin
    RST_N = 1'b0;
    CLR   = 1'b0;
    DINEN = 1'b0;
    DIN   = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    test_reset();
    test_back_to_back();
    test_sparse();
    test_intra();
    test_inter();
    test_equal_keys();
    test_overrun();
    test_clear_restart();
    test_reset_midrun();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
